// File: rtl/picture_buffer.sv
// Captures a raster stream of RGB pixels into a register tile exposed in parallel
// as o_buf[channel][row][col]; o_frame_done pulses after the tile's last pixel lands.
module picture_buffer #(
  parameter int DATA_W = 10,
  parameter int COLS   = 16,
  parameter int ROWS   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_R,
  input  logic [DATA_W-1:0] i_G,
  input  logic [DATA_W-1:0] i_B,
  input  logic              i_take,
  output logic [DATA_W-1:0] o_buf [0:2][0:ROWS-1][0:COLS-1],
  output logic              o_frame_done
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  logic [DATA_W-1:0] r_buf [0:2][0:ROWS-1][0:COLS-1];
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic              r_frame_done;
  logic [CW-1:0]     w_col_nxt;
  logic [RW-1:0]     w_row_nxt;
  logic              w_col_last;
  logic              w_row_last;

  // Raster-order pointer advance; holds whenever no pixel is taken.
  always_comb begin
    w_col_last = (r_col == COL_LAST);
    w_row_last = (r_row == ROW_LAST);
    w_col_nxt  = r_col;
    w_row_nxt  = r_row;
    if (i_take) begin
      if (w_col_last) begin
        w_col_nxt = '0;
        if (w_row_last) begin
          w_row_nxt = '0;
        end else begin
          w_row_nxt = r_row + RW'(1);
        end
      end else begin
        w_col_nxt = r_col + CW'(1);
        w_row_nxt = r_row;
      end
    end else begin
      w_col_nxt = r_col;
      w_row_nxt = r_row;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
      r_frame_done <= i_take & w_col_last & w_row_last;
    end
  end

  // Only the addressed entry of each channel is written; everything else holds.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int ch = 0; ch < 3; ch++) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            r_buf[ch][r][c] <= '0;
          end
        end
      end
    end else if (i_take) begin
      r_buf[0][r_row][r_col] <= i_R;
      r_buf[1][r_row][r_col] <= i_G;
      r_buf[2][r_row][r_col] <= i_B;
    end
  end

  assign o_buf        = r_buf;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_picture_buffer.sv
// Directed + randomized bench for picture_buffer against a linear-index tile model.
module tb_picture_buffer;

  localparam int DW = 10;
  localparam int NC = 16;
  localparam int NR = 16;
  localparam int NPIX = NC * NR;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [DW-1:0] i_R, i_G, i_B;
  logic          i_take;
  logic [DW-1:0] o_buf [0:2][0:NR-1][0:NC-1];
  logic          o_frame_done;

  int exp_buf [3][NR][NC];
  int p;
  int exp_fd;
  int n_pulses;
  int n_cmp = 0;
  int n_bad = 0;

  picture_buffer #(.DATA_W(DW), .COLS(NC), .ROWS(NR)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_R(i_R), .i_G(i_G), .i_B(i_B),
    .i_take(i_take), .o_buf(o_buf), .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic model_clear();
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < NC; c++) exp_buf[ch][r][c] = 0;
    p = 0;
    exp_fd = 0;
  endtask

  task automatic check_val(input string tag, input logic [DW-1:0] got, input int want);
    n_cmp++;
    assert (got === DW'(want)) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic check_fd(input string tag);
    n_cmp++;
    assert (o_frame_done === exp_fd[0]) else begin
      n_bad++;
      $error("FAIL %s: frame_done got %b expected %0d (pixel index %0d)", tag, o_frame_done, exp_fd, p);
    end
  endtask

  task automatic check_buf(input string tag);
    int bad = 0;
    int fc = 0, fr = 0, fk = 0;
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < NC; c++)
          if (o_buf[ch][r][c] !== DW'(exp_buf[ch][r][c])) begin
            if (bad == 0) begin fk = ch; fr = r; fc = c; end
            bad++;
          end
    n_cmp++;
    assert (bad === 0) else begin
      n_bad++;
      $error("FAIL %s: %0d entries differ, first [%0d][%0d][%0d] got %0d expected %0d",
             tag, bad, fk, fr, fc, o_buf[fk][fr][fc], exp_buf[fk][fr][fc]);
    end
  endtask

  // One clock: drive, apply the tile rules to the model, sample 1 unit after the edge.
  task automatic cyc(input logic take, input int r, input int g, input int b);
    i_take = take;
    i_R = DW'(r);
    i_G = DW'(g);
    i_B = DW'(b);
    @(posedge i_clk);
    exp_fd = 0;
    if (take) begin
      exp_buf[0][p / NC][p % NC] = r % (1 << DW);
      exp_buf[1][p / NC][p % NC] = g % (1 << DW);
      exp_buf[2][p / NC][p % NC] = b % (1 << DW);
      exp_fd = (p == NPIX - 1) ? 1 : 0;
      p = (p + 1) % NPIX;
    end
    #1;
    check_fd("frame_done");
    if (o_frame_done === 1'b1) n_pulses++;
  endtask

  task automatic rnd_cyc(input logic take);
    cyc(take, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
  endtask

  // Reset raised between edges with take high; the clear must be visible before any edge.
  task automatic async_reset();
    #2;
    i_take = 1'b1;
    i_R = DW'($urandom);
    i_G = DW'($urandom);
    i_B = DW'($urandom);
    i_rst = 1'b1;
    #1;
    model_clear();
    check_buf("async_reset_buf");
    check_fd("async_reset_fd");
    @(posedge i_clk);
    #1;
    check_buf("reset_held_buf");
    check_fd("reset_held_fd");
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    i_take = 1'b1;
    i_R = DW'($urandom);
    i_G = DW'($urandom);
    i_B = DW'($urandom);
    model_clear();
    n_pulses = 0;
    #7;
    check_buf("por_buf");
    check_fd("por_fd");
    i_rst = 1'b0;

    // Continuous capture of a full tile
    for (int k = 0; k < NPIX; k++) cyc(1'b1, 1 + k, 2 + k, 3 + k);
    check_buf("continuous_buf");
    check_val("cont_R_0_0", o_buf[0][0][0], 1);
    check_val("cont_G_3_7", o_buf[1][3][7], 2 + 16 * 3 + 7);
    check_val("cont_B_15_15", o_buf[2][15][15], 3 + 255);
    check_val("cont_pulses", DW'(n_pulses), 1);

    // Wrap: pixel 257 overwrites (0,0) only
    cyc(1'b1, 1000, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    check_val("wrap_R_0_0", o_buf[0][0][0], 1000);
    check_val("wrap_R_0_1_kept", o_buf[0][0][1], 2);
    for (int k = 1; k < NPIX; k++) rnd_cyc(1'b1);
    check_buf("wrap_buf");
    check_val("wrap_pulses", DW'(n_pulses), 2);

    // Hold mid-frame: nothing moves, then capture lands at (0,5)
    for (int k = 0; k < 5; k++) rnd_cyc(1'b1);
    for (int k = 0; k < 50; k++) rnd_cyc(1'b0);
    check_buf("hold_buf");
    cyc(1'b1, 777, 555, 333);
    check_val("hold_resume_R", o_buf[0][0][5], 777);
    check_val("hold_resume_B", o_buf[2][0][5], 333);
    check_buf("hold_resume_buf");

    // Alternating take from a fresh tile
    async_reset();
    for (int k = 0; k < 20; k++) cyc((k % 2) == 0, 1 + k, 2 + k, 3 + k);
    check_val("alt_R_0_0", o_buf[0][0][0], 1);
    check_val("alt_R_0_1", o_buf[0][0][1], 3);
    check_val("alt_R_0_2", o_buf[0][0][2], 5);
    check_buf("alt_buf");

    // Mid-frame reset after 100 captures, then restart at (0,0)
    async_reset();
    for (int k = 0; k < 100; k++) rnd_cyc(1'b1);
    n_pulses = 0;
    async_reset();
    cyc(1'b1, 111, 222, 444);
    check_val("post_reset_R", o_buf[0][0][0], 111);
    check_val("post_reset_G", o_buf[1][0][0], 222);
    check_buf("post_reset_buf");
    for (int k = 0; k < 155; k++) rnd_cyc(1'b1);
    check_val("aborted_frame_pulses", DW'(n_pulses), 0);

    // Random take/data mix across several wraps
    for (int k = 0; k < 900; k++) begin
      rnd_cyc(logic'($urandom_range(0, 1)));
      if ((k % 100) == 99) check_buf("random_buf");
    end
    check_buf("final_buf");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/picture_buffer.md
Name: picture_buffer

Overview:
- Captures a stream of RGB pixels (one pixel per enabled clock) into a 16x16 tile held in registers.
- Exposes the whole tile in parallel as o_buf[channel][row][col] for downstream object-tracking logic, e.g. template or feature comparison.
- Sits directly after the camera/pixel-format stage.
- Channel index 0 = R, 1 = G, 2 = B.

Parameters:
- DATA_W, 10, bit width of each colour sample.
- COLS, 16, tile width in pixels (column index range 0..COLS-1).
- ROWS, 16, tile height in pixels (row index range 0..ROWS-1).

Ports:
- i_clk  input  1  system clock; all state updates on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_R  input  DATA_W  red sample of the current pixel.
- i_G  input  DATA_W  green sample of the current pixel.
- i_B  input  DATA_W  blue sample of the current pixel.
- i_take  input  1  capture enable; the pixel on i_R/i_G/i_B is stored on a rising edge where i_take=1.
- o_buf  output  3 x ROWS x COLS x DATA_W  unpacked array [0:2][0:ROWS-1][0:COLS-1]; registered tile contents.
- o_frame_done  output  1  one-cycle pulse when the last pixel of the tile (row ROWS-1, col COLS-1) is written.

Behaviour:
- Reset (i_rst=1, asynchronous):
  - every o_buf entry = 0
  - write pointer row=0, col=0
  - o_frame_done=0
- Reset takes effect immediately regardless of the clock, including mid-frame.
- After release, capture restarts at (0,0).
- Write pointer: row-major raster order.
  - col increments on each capture.
  - When col=COLS-1 is captured, col returns to 0 and row increments.
  - When (ROWS-1, COLS-1) is captured, pointer wraps to (0,0).
- Capture, on a rising edge with i_take=1:
  - o_buf[0][row][col] <= i_R, o_buf[1][row][col] <= i_G, o_buf[2][row][col] <= i_B.
  - Pointer then advances.
  - Latency: the stored value is visible on o_buf the cycle after the edge.
- i_take=0: no write, pointer holds, o_buf holds.
- i_take is sampled as a level, not an edge.
  - Held high for N cycles -> N consecutive pixels.
  - Toggling every cycle -> one pixel every other cycle.
- Wrap-around: after a full tile, the next capture overwrites (0,0). The buffer is rolling; older entries stay valid until overwritten.
- o_frame_done:
  - Registered; =1 for exactly the cycle following the edge that writes (ROWS-1, COLS-1), else 0.
  - Not asserted if reset occurs before that write.
- Only the addressed entry changes on a capture; all other entries hold.
- Samples are stored verbatim: no arithmetic, no saturation, full DATA_W bits.
- Reset has priority over i_take.

Test Plan:
- Reset: assert i_rst with random inputs and i_take=1 -> all 768 o_buf entries = 0, o_frame_done=0, immediately (asynchronously).
- Continuous capture: i_take=1 for 256 cycles with R=1+k, G=2+k, B=3+k at cycle k -> o_buf[0][r][c]=1+16r+c, o_buf[1][r][c]=2+16r+c, o_buf[2][r][c]=3+16r+c. o_frame_done pulses once, one cycle after the 256th capture.
- Alternating take: i_take toggles every cycle (high first) while R/G/B increment every cycle from 1/2/3 -> only high-cycle values stored; o_buf[0][0][0]=1, o_buf[0][0][1]=3, o_buf[0][0][2]=5.
- Wrap: continue continuous capture past 256 pixels with R=1000 on the 257th -> o_buf[0][0][0]=1000, o_buf[0][0][1] unchanged, o_frame_done pulses again after pixel 512.
- Hold: i_take=0 for 50 cycles with changing inputs -> o_buf unchanged, next capture lands at the pointer position reached before the hold.
- Mid-frame reset: reset pulse after 100 captures -> buffer cleared, next capture writes (0,0), no o_frame_done for the aborted frame.
